// File: rtl/topk_accum_4.sv
// Running top-4 accumulator over frames of descending-sorted 4-element groups.
// Each accepted group is max-merged into the accumulator; the frame result is offered on a valid/ready port.
module topk_accum_4 #(
    parameter int DATAWIDTH  = 8,
    parameter int DATALENGTH = 4,
    parameter int CNTWIDTH   = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            in_valid_i,
    input  logic                            in_last_i,
    input  logic [DATALENGTH*DATAWIDTH-1:0] in_data_i,
    output logic                            in_ready_o,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [DATALENGTH*DATAWIDTH-1:0] out_data_o,
    output logic [CNTWIDTH-1:0]             out_count_o
);

    localparam int W = DATALENGTH * DATAWIDTH;

    if (DATALENGTH != 4) begin : g_bad_length
        $error("topk_accum_4 supports DATALENGTH == 4 only");
    end

    // Valid/ready: a transfer happens on a rising edge where valid && ready are both high.
    // S_HOLD means a frame result is being presented and has not yet been consumed.
    typedef enum logic {
        S_ACCUM = 1'b0,
        S_HOLD  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [W-1:0]        acc_q, acc_d;
    logic [CNTWIDTH-1:0] cnt_q, cnt_d;
    logic [W-1:0]        res_q, res_d;
    logic [CNTWIDTH-1:0] rcnt_q, rcnt_d;
    logic [W-1:0]        merged;
    logic [CNTWIDTH-1:0] cnt_inc;
    logic                accept;

    // Bitonic max-merge of two descending groups, then a two-stage half-cleaner.
    function automatic logic [W-1:0] merge4(input logic [W-1:0] r, input logic [W-1:0] x);
        logic [DATAWIDTH-1:0] b [4];
        logic [DATAWIDTH-1:0] ri;
        logic [DATAWIDTH-1:0] xi;
        logic [DATAWIDTH-1:0] t;
        logic [W-1:0]         res;
        for (int i = 0; i < 4; i++) begin
            ri   = r[i*DATAWIDTH +: DATAWIDTH];
            xi   = x[(3-i)*DATAWIDTH +: DATAWIDTH];
            b[i] = (ri > xi) ? ri : xi;
        end
        if (b[2] > b[0]) begin t = b[0]; b[0] = b[2]; b[2] = t; end
        if (b[3] > b[1]) begin t = b[1]; b[1] = b[3]; b[3] = t; end
        if (b[1] > b[0]) begin t = b[0]; b[0] = b[1]; b[1] = t; end
        if (b[3] > b[2]) begin t = b[2]; b[2] = b[3]; b[3] = t; end
        res = '0;
        for (int i = 0; i < 4; i++) begin
            res[i*DATAWIDTH +: DATAWIDTH] = b[i];
        end
        return res;
    endfunction

    assign in_ready_o  = (state_q == S_ACCUM) || out_ready_i;
    assign out_valid_o = (state_q == S_HOLD);
    assign out_data_o  = res_q;
    assign out_count_o = rcnt_q;
    assign accept      = in_valid_i && in_ready_o;
    assign merged      = merge4(acc_q, in_data_i);
    assign cnt_inc     = (cnt_q == {CNTWIDTH{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        rcnt_d  = rcnt_q;
        if (out_ready_i) begin
            state_d = S_ACCUM;
        end
        if (accept) begin
            if (in_last_i) begin
                // Closing beat: publish the result and start the next frame from zero.
                res_d   = merged;
                rcnt_d  = cnt_inc;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = S_HOLD;
            end else begin
                acc_d = merged;
                cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            rcnt_q  <= rcnt_d;
        end
    end

endmodule

// File: tb/tb_topk_accum_4.sv
// Bench for topk_accum_4: directed scenarios plus random frames against a sort-and-take-4 reference.
module tb_topk_accum_4;

    localparam int DW = 8;
    localparam int W  = 4 * DW;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_last;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [CW-1:0] out_count;
    logic          in_ready2;
    logic          out_valid2;
    logic [W-1:0]  out_data2;
    logic [1:0]    out_count2;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0]  exp_q [$];
    logic [CW-1:0] expc_q [$];
    int unsigned   frame_vals [$];
    int            beats = 0;
    bit            rand_ready = 1'b0;
    logic [W-1:0]  mon_d;
    logic [CW-1:0] mon_c;

    always #5 clk = ~clk;

    topk_accum_4 #(.DATAWIDTH(DW), .DATALENGTH(4), .CNTWIDTH(CW)) dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_last_i(in_last),
        .in_data_i(in_data), .in_ready_o(in_ready), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .out_data_o(out_data), .out_count_o(out_count)
    );

    // Narrow counter instance, used for the saturation scenario.
    topk_accum_4 #(.DATAWIDTH(DW), .DATALENGTH(4), .CNTWIDTH(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_last_i(in_last),
        .in_data_i(in_data), .in_ready_o(in_ready2), .out_valid_o(out_valid2),
        .out_ready_i(out_ready), .out_data_o(out_data2), .out_count_o(out_count2)
    );

    function automatic logic [W-1:0] pk(input int unsigned a, input int unsigned b,
                                        input int unsigned c, input int unsigned d);
        return {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    // Reference: top-4 of a frame is the four largest of all its elements.
    task automatic model_accept(input logic [W-1:0] d, input bit last);
        for (int e = 0; e < 4; e++) frame_vals.push_back(int'(d[e*DW +: DW]));
        beats++;
        if (last) begin
            frame_vals.rsort();
            exp_q.push_back(pk(frame_vals[0], frame_vals[1], frame_vals[2], frame_vals[3]));
            expc_q.push_back((beats > 65535) ? 16'hFFFF : CW'(beats));
            frame_vals.delete();
            beats = 0;
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_result got data=%h count=%0d required none", out_data, out_count);
            end else begin
                mon_d = exp_q.pop_front();
                mon_c = expc_q.pop_front();
                if (out_data !== mon_d || out_count !== mon_c) begin
                    failures++;
                    $display("FAIL result got data=%h count=%0d required data=%h count=%0d",
                             out_data, out_count, mon_d, mon_c);
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    // All driver tasks start and end 1 time unit after a rising edge.
    task automatic send_beat(input logic [W-1:0] d, input bit last);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL send_timeout got accepted=0 required accepted=1 data=%h", d);
        end else begin
            model_accept(d, last);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 400 && exp_q.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got pending=%0d required pending=0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_count !== '0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_state got v=%b d=%h c=%0d r=%b required v=0 d=0 c=0 r=1",
                     out_valid, out_data, out_count, in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_three_beat();
        out_ready = 1'b1;
        send_beat(pk(9, 7, 3, 1), 1'b0);
        send_beat(pk(8, 6, 5, 2), 1'b0);
        @(negedge clk);
        checks++;
        if (dut.acc_q !== pk(9, 8, 7, 6)) begin
            failures++;
            $display("FAIL acc_after_two got %h required %h", dut.acc_q, pk(9, 8, 7, 6));
        end
        @(posedge clk);
        #1;
        send_beat(pk(10, 4, 4, 0), 1'b1);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== pk(10, 9, 8, 7) || out_count !== 16'd3) begin
            failures++;
            $display("FAIL three_beat got v=%b d=%h c=%0d required v=1 d=%h c=3",
                     out_valid, out_data, out_count, pk(10, 9, 8, 7));
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL valid_one_cycle got v=%b required v=0", out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send_beat(pk(5, 5, 2, 0), 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== pk(5, 5, 2, 0) || out_count !== 16'd1) begin
                failures++;
                $display("FAIL hold_stable cyc=%0d got r=%b v=%b d=%h c=%0d required r=0 v=1 d=%h c=1",
                         i, in_ready, out_valid, out_data, out_count, pk(5, 5, 2, 0));
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send_beat(pk(4, 3, 2, 1), 1'b1);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== pk(4, 3, 2, 1) || out_count !== 16'd1) begin
            failures++;
            $display("FAIL swap_result got v=%b d=%h c=%0d required v=1 d=%h c=1",
                     out_valid, out_data, out_count, pk(4, 3, 2, 1));
        end
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic test_reset_mid_frame();
        out_ready = 1'b1;
        send_beat(pk(200, 100, 50, 25), 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        frame_vals.delete();
        beats = 0;
        send_beat(pk(3, 2, 1, 0), 1'b1);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== pk(3, 2, 1, 0) || out_count !== 16'd1) begin
            failures++;
            $display("FAIL reset_mid_frame got v=%b d=%h c=%0d required v=1 d=%h c=1",
                     out_valid, out_data, out_count, pk(3, 2, 1, 0));
        end
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic test_saturation();
        out_ready = 1'b1;
        for (int b = 0; b < 6; b++) send_beat(pk(1, 1, 1, 1), b == 5);
        @(negedge clk);
        checks++;
        if (out_valid2 !== 1'b1 || out_count2 !== 2'd3 || out_data2 !== pk(1, 1, 1, 1)) begin
            failures++;
            $display("FAIL saturation got v=%b d=%h c=%0d required v=1 d=%h c=3",
                     out_valid2, out_data2, out_count2, pk(1, 1, 1, 1));
        end
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic test_random();
        int unsigned v [$];
        int          nb;
        int          hi;
        rand_ready = 1'b1;
        for (int f = 0; f < 1000; f++) begin
            nb = $urandom_range(1, 20);
            for (int b = 0; b < nb; b++) begin
                v.delete();
                hi = ($urandom_range(0, 3) == 0) ? 15 : 255;
                for (int e = 0; e < 4; e++) v.push_back($urandom_range(0, hi));
                if ($urandom_range(0, 15) == 0) v = '{0, 0, 0, 0};
                v.rsort();
                send_beat(pk(v[0], v[1], v[2], v[3]), b == nb - 1);
            end
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        drain();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_three_beat();
        test_backpressure();
        test_reset_mid_frame();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
